// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// parity mode constants and receive-data word bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_WAITMARK = 3'd0,
    ST_IDLE     = 3'd1,
    ST_CHKSTART = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_PARITY   = 3'd4,
    ST_STOP1    = 3'd5,
    ST_STOP2    = 3'd6,
    ST_BREAK    = 3'd7
  } rx_state_e;

  localparam logic [1:0] PAR_ODD   = 2'd0;
  localparam logic [1:0] PAR_EVEN  = 2'd1;
  localparam logic [1:0] PAR_SPACE = 2'd2;
  localparam logic [1:0] PAR_MARK  = 2'd3;

  // Flag positions sit directly above the right-justified data field.
  function automatic int rd_pe_bit(input int max_len);
    return max_len;
  endfunction

  function automatic int rd_fe_bit(input int max_len);
    return max_len + 1;
  endfunction

  function automatic int rd_brk_bit(input int max_len);
    return max_len + 2;
  endfunction

endpackage

// File: rtl/uart_rx_bitclk.sv
// Receive bit timing: RxD synchroniser, 3-sample majority vote and the
// oversampling prescaler whose terminal count marks each bit centre.
module uart_rx_bitclk #(
  parameter int pOvrSmp = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic CE_Ovr,
  input  logic RxD,
  input  logic Load,
  output logic RxS,
  output logic Vote,
  output logic TC
);

  localparam int PW = $clog2(pOvrSmp);
  localparam logic [PW-1:0] HALF_M1 = PW'(pOvrSmp / 2 - 1);
  localparam logic [PW-1:0] FULL_M1 = PW'(pOvrSmp - 1);

  logic [1:0]    sync_q;
  logic [2:0]    hist_q;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q  <= 2'b11;
      hist_q  <= 3'b111;
      presc_q <= HALF_M1;
    end else begin
      sync_q  <= {sync_q[0], RxD};
      if (CE_Ovr) begin
        hist_q <= {hist_q[1:0], sync_q[1]};
      end
      presc_q <= presc_d;
    end
  end

  assign RxS  = sync_q[1];
  assign Vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  assign TC   = CE_Ovr && (presc_q == '0);

  // A start detect re-phases the count to land on the middle of the start bit.
  always_comb begin
    presc_d = presc_q;
    if (Load) begin
      presc_d = HALF_M1;
    end else if (TC) begin
      presc_d = FULL_M1;
    end else if (CE_Ovr) begin
      presc_d = presc_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start validation, LSB-first data capture, parity and
// stop checking, line-break detection and the receive holding register write.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int pOvrSmp = 16,
  parameter int pMaxLen = 9
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               CE_Ovr,
  input  logic [3:0]         Len,
  input  logic               NumStop,
  input  logic               ParEn,
  input  logic [1:0]         Par,
  input  logic               RxD,
  output logic [pMaxLen+2:0] RD,
  output logic               WE_RHR,
  output logic               RxIdle,
  output logic               RxBusy,
  output logic               RxBreak
);

  localparam int PE_B  = rd_pe_bit(pMaxLen);
  localparam int FE_B  = rd_fe_bit(pMaxLen);
  localparam int BRK_B = rd_brk_bit(pMaxLen);
  localparam logic [3:0] MAX_LEN = 4'(pMaxLen);

  rx_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [pMaxLen-1:0]   shreg_q, shreg_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 brk_q, brk_d;
  logic                 parbit_q, parbit_d;
  logic                 mark_q, mark_d;
  logic [pMaxLen+2:0]   rd_q, rd_d;
  logic                 we_q, we_d;

  logic                 rxs, vote, tc, load;
  logic [3:0]           eff_len;
  logic [3:0]           bit_idx;
  logic                 is_brk;

  uart_rx_bitclk #(.pOvrSmp(pOvrSmp)) u_bitclk (
    .Clk    (Clk),
    .Rst    (Rst),
    .CE_Ovr (CE_Ovr),
    .RxD    (RxD),
    .Load   (load),
    .RxS    (rxs),
    .Vote   (vote),
    .TC     (tc)
  );

  always_comb begin
    if (Len < 4'd5) begin
      eff_len = 4'd5;
    end else if (Len > MAX_LEN) begin
      eff_len = MAX_LEN;
    end else begin
      eff_len = Len;
    end
  end

  // Wraps to a large value if Len moves mid-character; such bits are dropped.
  assign bit_idx = eff_len - 4'd1 - cnt_q;
  assign is_brk  = (shreg_q == '0) && (!ParEn || !parbit_q);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_WAITMARK;
      cnt_q    <= '0;
      shreg_q  <= '0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      brk_q    <= 1'b0;
      parbit_q <= 1'b0;
      mark_q   <= 1'b0;
      rd_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      brk_q    <= brk_d;
      parbit_q <= parbit_d;
      mark_q   <= mark_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    pe_d     = pe_q;
    fe_d     = fe_q;
    brk_d    = brk_q;
    parbit_d = parbit_q;
    mark_d   = 1'b0;
    rd_d     = rd_q;
    we_d     = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_WAITMARK: begin
        mark_d = mark_q;
        if (CE_Ovr) begin
          if (rxs && mark_q) begin
            state_d = ST_IDLE;
            mark_d  = 1'b0;
          end else begin
            mark_d = rxs;
          end
        end
      end
      ST_IDLE: begin
        if (CE_Ovr && !rxs) begin
          state_d = ST_CHKSTART;
          load    = 1'b1;
        end
      end
      ST_CHKSTART: begin
        if (tc) begin
          if (vote) begin
            state_d = ST_IDLE;
          end else begin
            shreg_d  = '0;
            cnt_d    = eff_len - 4'd1;
            pe_d     = 1'b0;
            fe_d     = 1'b0;
            brk_d    = 1'b0;
            parbit_d = 1'b0;
            state_d  = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (tc) begin
          for (int i = 0; i < pMaxLen; i++) begin
            if (bit_idx == 4'(i)) begin
              shreg_d[i] = vote;
            end
          end
          if (cnt_q == 4'd0) begin
            if (ParEn) begin
              state_d = ST_PARITY;
            end else if (NumStop) begin
              state_d = ST_STOP2;
            end else begin
              state_d = ST_STOP1;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tc) begin
          parbit_d = vote;
          case (Par)
            PAR_ODD:   pe_d = ~((^shreg_q) ^ vote);
            PAR_EVEN:  pe_d = (^shreg_q) ^ vote;
            PAR_SPACE: pe_d = vote;
            default:   pe_d = ~vote;
          endcase
          state_d = NumStop ? ST_STOP2 : ST_STOP1;
        end
      end
      ST_STOP2: begin
        if (tc) begin
          if (!vote) begin
            fe_d = 1'b1;
          end
          state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (tc) begin
          we_d = 1'b1;
          if (vote) begin
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            brk_d   = is_brk;
            state_d = is_brk ? ST_BREAK : ST_WAITMARK;
          end
          rd_d                = '0;
          rd_d[pMaxLen-1:0]   = shreg_q;
          rd_d[PE_B]          = pe_q;
          rd_d[FE_B]          = fe_d;
          rd_d[BRK_B]         = brk_d;
        end
      end
      ST_BREAK: begin
        if (CE_Ovr && rxs) begin
          state_d = ST_WAITMARK;
        end
      end
      default: state_d = ST_WAITMARK;
    endcase
  end

  assign RD      = rd_q;
  assign WE_RHR  = we_q;
  assign RxIdle  = (state_q == ST_IDLE);
  assign RxBusy  = (state_q == ST_CHKSTART) || (state_q == ST_SHIFT) || (state_q == ST_PARITY) ||
                   (state_q == ST_STOP1) || (state_q == ST_STOP2);
  assign RxBreak = (state_q == ST_BREAK);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus random frames
// compared against a frame-level model of the expected receive word.
module tb_uart_rx_core;

  localparam int OVR    = 16;
  localparam int MAXL   = 9;
  localparam int RDW    = MAXL + 3;
  localparam int CE_DIV = 4;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           CE_Ovr = 1'b0;
  logic [3:0]     Len = 4'd8;
  logic           NumStop = 1'b0;
  logic           ParEn = 1'b0;
  logic [1:0]     Par = 2'd0;
  logic           RxD = 1'b1;
  logic [RDW-1:0] RD;
  logic           WE_RHR, RxIdle, RxBusy, RxBreak;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;
  logic [RDW-1:0] wr_q[$];
  int             wr_tick[$];

  uart_rx_core #(.pOvrSmp(OVR), .pMaxLen(MAXL)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .CE_Ovr  (CE_Ovr),
    .Len     (Len),
    .NumStop (NumStop),
    .ParEn   (ParEn),
    .Par     (Par),
    .RxD     (RxD),
    .RD      (RD),
    .WE_RHR  (WE_RHR),
    .RxIdle  (RxIdle),
    .RxBusy  (RxBusy),
    .RxBreak (RxBreak)
  );

  always #5 Clk = ~Clk;

  initial begin
    forever begin
      repeat (CE_DIV - 1) @(posedge Clk);
      #1 CE_Ovr = 1'b1;
      @(posedge Clk);
      #1 CE_Ovr = 1'b0;
    end
  end

  always @(posedge Clk) if (CE_Ovr) tick_cnt <= tick_cnt + 1;

  // Every write seen is logged, so a stretched pulse shows up as extra writes.
  always @(negedge Clk) begin
    if (WE_RHR) begin
      wr_q.push_back(RD);
      wr_tick.push_back(tick_cnt);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge Clk); while (CE_Ovr !== 1'b1);
    end
    #2;
  endtask

  task automatic send_bit(input logic v, input logic glitch);
    if (glitch) begin
      RxD = v;  wait_ticks(7);
      RxD = ~v; wait_ticks(1);
      RxD = v;  wait_ticks(OVR - 8);
    end else begin
      RxD = v;  wait_ticks(OVR);
    end
  endtask

  // Sends one character, then compares the logged write(s) with the model.
  task automatic frame(input string tag, input logic [3:0] len, input logic ns, input logic pen,
                       input logic [1:0] par, input logic [8:0] data, input logic bad_par,
                       input logic bad_first, input logic bad_last, input int glitch_bit,
                       output int lat);
    int             eff, st;
    logic [8:0]     d;
    logic           pbit, pe, fe, brk;
    logic [RDW-1:0] exp_rd;
    logic [2:0]     exp_flags, post_flags;
    eff = (len < 5) ? 5 : ((len > MAXL) ? MAXL : int'(len));
    d = '0;
    for (int i = 0; i < eff; i++) d[i] = data[i];
    case (par)
      2'd0:    pbit = ($countones(d) % 2 == 0);
      2'd1:    pbit = ($countones(d) % 2 == 1);
      2'd2:    pbit = 1'b0;
      default: pbit = 1'b1;
    endcase
    if (bad_par) pbit = ~pbit;
    pe  = pen && bad_par;
    fe  = bad_last || (ns && bad_first);
    brk = bad_last && (d == 0) && (!pen || !pbit);
    exp_rd = {brk, fe, pe, d};
    exp_flags = !bad_last ? 3'b100 : (brk ? 3'b001 : 3'b000);

    Len = len; NumStop = ns; ParEn = pen; Par = par;
    wr_q.delete(); wr_tick.delete();
    st = tick_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < eff; i++) send_bit(d[i], glitch_bit == i);
    if (pen) send_bit(pbit, 1'b0);
    if (ns) send_bit(~bad_first, 1'b0);
    send_bit(~bad_last, 1'b0);
    post_flags = {RxIdle, RxBusy, RxBreak};
    RxD = 1'b1;
    wait_ticks(24);

    check({tag, "_nwr"}, wr_q.size(), 1);
    check({tag, "_rd"}, (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hDEAD_BEEF, 32'(exp_rd));
    check({tag, "_state"}, post_flags, exp_flags);
    lat = (wr_tick.size() > 0) ? wr_tick[0] - st : -1;
    $display("frame %s len=%0d ns=%0d pen=%0d par=%0d data=0x%0h exp_rd=0x%0h writes=%0d lat=%0d",
             tag, len, ns, pen, par, d, exp_rd, wr_q.size(), lat);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge Clk);
    #2;
    check("rst_rd", RD, 0);
    check("rst_we", WE_RHR, 0);
    check("rst_flags", {RxIdle, RxBusy, RxBreak}, 3'b000);
    Rst = 1'b0;
    wait_ticks(4);
    check("mark_to_idle", RxIdle, 1);

    // 8N1 0xA5; the write lands about 9.5 bit times after the start edge.
    frame("8n1_a5", 4'd8, 1'b0, 1'b0, 2'd0, 9'h0A5, 1'b0, 1'b0, 1'b0, -1, lat);
    check("8n1_latency_window", (lat >= 150 && lat <= 156), 1);

    frame("7e2_badpar", 4'd7, 1'b1, 1'b1, 2'd1, 9'h041, 1'b1, 1'b0, 1'b0, -1, lat);
    frame("7e2_badstop2", 4'd7, 1'b1, 1'b1, 2'd1, 9'h041, 1'b0, 1'b0, 1'b1, -1, lat);

    // Short start pulse must be rejected as a glitch.
    wr_q.delete();
    Len = 4'd8; NumStop = 1'b0; ParEn = 1'b0;
    RxD = 1'b0; wait_ticks(4);
    RxD = 1'b1; wait_ticks(24);
    check("short_start_nwr", wr_q.size(), 0);
    check("short_start_idle", RxIdle, 1);
    $display("short start pulse: writes=%0d idle=%0d", wr_q.size(), RxIdle);

    frame("glitch_55", 4'd8, 1'b0, 1'b0, 2'd0, 9'h055, 1'b0, 1'b0, 1'b0, 3, lat);

    // Line held low for three character times.
    wr_q.delete();
    Len = 4'd8; NumStop = 1'b0; ParEn = 1'b0;
    RxD = 1'b0; wait_ticks(3 * 10 * OVR);
    check("brk_hold", RxBreak, 1);
    RxD = 1'b1; wait_ticks(1);
    check("brk_exit_flags", {RxIdle, RxBusy, RxBreak}, 3'b000);
    wait_ticks(2);
    check("brk_idle", RxIdle, 1);
    check("brk_nwr", wr_q.size(), 1);
    check("brk_rd", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hDEAD_BEEF, 32'h0C00);
    $display("break: writes=%0d", wr_q.size());

    frame("9o1_1ff", 4'd9, 1'b0, 1'b1, 2'd0, 9'h1FF, 1'b0, 1'b0, 1'b0, -1, lat);
    frame("len5_1f", 4'd5, 1'b0, 1'b0, 2'd0, 9'h1FF, 1'b0, 1'b0, 1'b0, -1, lat);
    frame("len3_as5", 4'd3, 1'b0, 1'b0, 2'd0, 9'h01B, 1'b0, 1'b0, 1'b0, -1, lat);

    // Reset in the middle of the data bits.
    wr_q.delete();
    Len = 4'd8; NumStop = 1'b0; ParEn = 1'b0;
    RxD = 1'b0; wait_ticks(OVR);
    RxD = 1'b1; wait_ticks(OVR);
    RxD = 1'b0; wait_ticks(OVR / 2);
    check("rst_mid_busy_before", RxBusy, 1);
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk);
    check("rst_mid_rd", RD, 0);
    check("rst_mid_we", WE_RHR, 0);
    check("rst_mid_flags", {RxIdle, RxBusy, RxBreak}, 3'b000);
    Rst = 1'b0; RxD = 1'b1;
    wait_ticks(30);
    check("rst_mid_nwr", wr_q.size(), 0);
    $display("reset mid-shift: writes=%0d", wr_q.size());
    frame("post_rst", 4'd8, 1'b0, 1'b0, 2'd0, 9'h03C, 1'b0, 1'b0, 1'b0, -1, lat);

    for (int k = 0; k < 16; k++) begin
      logic [3:0] l;
      logic ns, pen, bp, bf, bl;
      logic [1:0] p;
      logic [8:0] dt;
      l   = 4'($urandom_range(0, 15));
      ns  = 1'($urandom_range(0, 1));
      pen = 1'($urandom_range(0, 1));
      p   = 2'($urandom_range(0, 3));
      dt  = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom);
      bp  = pen && ($urandom_range(0, 3) == 0);
      bf  = ns && ($urandom_range(0, 3) == 0);
      bl  = ($urandom_range(0, 3) == 0);
      frame($sformatf("rnd%0d", k), l, ns, pen, p, dt, bp, bf, bl, -1, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised receive engine for the Parallel Interface UART. Replaces the fixed 16x, 7/8-bit receive state machine. Adds:
- configurable oversampling factor and maximum word length (5..pMaxLen bits);
- an RxD input synchroniser;
- 3-sample majority voting at mid-bit;
- explicit line-break detection.

It sits between the baud-rate generator (CE_Ovr) and the receive holding register/FIFO (RD, WE_RHR).

## Interface
- pOvrSmp, 16, oversampling ratio; even, 8..32
- pMaxLen, 9, maximum data bits; 5..9
- Clk  in  1  system clock
- Rst  in  1  reset, synchronous, active-high
- CE_Ovr  in  1  clock enable at baud × pOvrSmp
- Len  in  4  data bits; <5 treated as 5, >pMaxLen treated as pMaxLen
- NumStop  in  1  0: 1 stop bit; 1: 2 stop bits
- ParEn  in  1  parity bit present
- Par  in  2  0 odd, 1 even, 2 space, 3 mark
- RxD  in  1  asynchronous serial input
- RD  out  pMaxLen+3  [pMaxLen+2] BRK, [pMaxLen+1] FE, [pMaxLen] PE, [pMaxLen-1:0] data
- WE_RHR  out  1  one-Clk write pulse for RD
- RxIdle  out  1  state == Idle
- RxBusy  out  1  state in {ChkStart, Shift, Parity, Stop1, Stop2}
- RxBreak  out  1  state == Break

## Operation
- RxD passes through a 2-flop synchroniser (reset to 1) to give RxS.
- A 3-bit history register shifts in RxS on each CE_Ovr.
- Vote = majority of the history register.
- Prescaler:
  - load pOvrSmp/2−1 on Idle→ChkStart;
  - load pOvrSmp−1 on each TC;
  - decrement on CE_Ovr;
  - TC = CE_Ovr & prescaler==0.
- In WaitMark, Idle and Break the state machine advances on CE_Ovr. In all other states it advances on TC.
- State transitions:
  - WaitMark: 2 consecutive CE_Ovr with RxS=1 → Idle; any RxS=0 restarts the count.
  - Idle: RxS=0 → ChkStart.
  - ChkStart: Vote=1 → Idle (glitch rejected); otherwise clear shift register, bit counter := eff_len−1 → Shift.
  - Shift: shift register [pMaxLen-1:0] receives Vote at bit index (eff_len−1−counter), so data is LSB first and right-justified; upper unused bits are 0. At counter==0: ParEn → Parity, else NumStop → Stop2, else Stop1. Otherwise decrement the counter.
  - Parity: PE := odd: XOR(data,Vote)==0; even: XOR(data,Vote)==1; space: Vote; mark: ~Vote. Then NumStop → Stop2, else Stop1.
  - Stop2: Vote=1 → Stop1; Vote=0 → FE:=1, go to Stop1.
  - Stop1:
    - Vote=1: write → Idle.
    - Vote=0: FE:=1, write → WaitMark.
    - Vote=0 with all data bits 0 and (parity bit 0 or ParEn=0): also BRK:=1, write → Break.
  - Break: stays until RxS=1 on a CE_Ovr, then → WaitMark. No further write during the break.
- A write loads RD from {BRK, FE, PE, data} and pulses WE_RHR.
- PE=0 when ParEn=0. FE/PE/BRK are per-character and cleared in ChkStart.
- Len, NumStop, ParEn and Par are sampled continuously. Software changes them only while RxIdle. Changing them mid-character is undefined but must not hang the FSM.
- Unused state encodings → WaitMark.

## Timing
- Reset values:
  - state = WaitMark;
  - RD = 0, WE_RHR = 0;
  - RxIdle = 0, RxBusy = 0, RxBreak = 0;
  - synchroniser = 1, history = 3'b111, prescaler = pOvrSmp/2−1.
- Start-edge latency: 2 Clk synchroniser, plus detection on the next CE_Ovr.
- First TC occurs pOvrSmp/2 CE_Ovr ticks after the start detect, i.e. mid start bit. Each later TC is pOvrSmp ticks apart.
- WE_RHR goes high the Clk after the Stop1 TC, for exactly one Clk. RD is valid from the same edge and holds until the next write.
- Back-to-back characters: Stop1→Idle on the mid-stop TC, so a start edge half a bit later is accepted.
- Rst mid-character: the next Clk returns to reset values. No write is issued.

## Structure
- Shared package uart_pkg holds:
  - state encodings for WaitMark, Idle, ChkStart, Shift, Parity, Stop1, Stop2, Break;
  - Par constants ODD/EVEN/SPACE/MARK;
  - RD bit-position constants as functions of pMaxLen.
- One sub-module, uart_rx_bitclk, contains the synchroniser, history/majority vote and prescaler. Its outputs are RxS, Vote and TC.

## Test plan
- 8N1, pOvrSmp=16, byte 0xA5 → RD=0x0A5 with flags 0, one WE_RHR pulse about 9.5 bit times after the start edge.
- 7E2 on 0x41 with a corrupted parity bit → data 0x41, PE=1, FE=0. Repeat with 2nd stop = 0 → FE=1, then state WaitMark.
- Start pulse of 4 CE_Ovr ticks → back to Idle, no WE_RHR. Single-tick glitch mid-bit on 0x55 → still 0x55.
- RxD held low for 3 character times (8N1) → exactly one write with BRK=1, FE=1, data 0; RxBreak high until RxD returns to 1, then Idle after 2 mark ticks.
- pMaxLen=9, Len=9, 9O1, 0x1FF → data 0x1FF, PE=0. Len=5, 0x1F → upper bits 0. Len=3 behaves as 5.
- Rst asserted mid-Shift → all outputs at reset values next Clk, no write. Then a full 8N1 byte is received correctly.
